// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encoding and master port IDs.
`default_nettype none
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_DBG = 1'b1;

  // Wide enough for MEM_LATENCY up to 15.
  localparam int LAT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// Two-way round-robin picker: the port not granted last wins a tie; one-hot grant.
`default_nettype none
module rr_arbiter_2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant == ARB_PORT_DBG))
      gnt[0] = 1'b1;
    else if (req[1])
      gnt[1] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// Shares one data-RAM port between the CPU (port 0) and a debug/loader master (port 1).
`default_nettype none
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              CK_REF,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_READ_WRN,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_ACK,
  output logic              CPU_HALT,
  input  logic              DBG_REQ,
  input  logic              DBG_READ_WRN,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic              DBG_ACK,
  output logic              MEM_EN,
  output logic              MEM_ACCESS_READ_WRN,
  output logic [ADDR_W-1:0] MEM_ACCESS_ADDRESS_BUS,
  output logic [DATA_W-1:0] MEM_ACCESS_DATA_OUT_BUS,
  input  logic [DATA_W-1:0] MEM_ACCESS_DATA_IN_BUS
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LATENCY - 1);

  arb_state_t           state;
  logic                 last_grant;
  logic                 winner;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [1:0]           gnt;

  rr_arbiter_2 u_rr (
    .req        ({DBG_REQ, CPU_REQ}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Low in the ACK cycle so the pipeline advances exactly once per access.
  assign CPU_HALT = CPU_REQ & ~CPU_ACK;

  // The MEM_ACCESS_* registers double as the command registers, so the bus
  // stays frozen for the whole ACCESS phase regardless of master activity.
  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      state                   <= ARB_IDLE;
      last_grant              <= ARB_PORT_DBG;
      winner                  <= ARB_PORT_CPU;
      lat_cnt                 <= '0;
      MEM_EN                  <= 1'b0;
      MEM_ACCESS_READ_WRN     <= 1'b1;
      MEM_ACCESS_ADDRESS_BUS  <= '0;
      MEM_ACCESS_DATA_OUT_BUS <= '0;
      CPU_ACK                 <= 1'b0;
      DBG_ACK                 <= 1'b0;
      CPU_RDATA               <= '0;
      DBG_RDATA               <= '0;
    end else begin
      CPU_ACK <= 1'b0;
      DBG_ACK <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|gnt) begin
            winner                  <= gnt[1];
            last_grant              <= gnt[1];
            MEM_ACCESS_READ_WRN     <= gnt[1] ? DBG_READ_WRN : CPU_READ_WRN;
            MEM_ACCESS_ADDRESS_BUS  <= gnt[1] ? DBG_ADDR     : CPU_ADDR;
            MEM_ACCESS_DATA_OUT_BUS <= gnt[1] ? DBG_WDATA    : CPU_WDATA;
            lat_cnt                 <= LAT_INIT;
            MEM_EN                  <= 1'b1;
            state                   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt == '0) begin
            if (MEM_ACCESS_READ_WRN) begin
              if (winner == ARB_PORT_DBG) DBG_RDATA <= MEM_ACCESS_DATA_IN_BUS;
              else                        CPU_RDATA <= MEM_ACCESS_DATA_IN_BUS;
            end
            if (winner == ARB_PORT_DBG) DBG_ACK <= 1'b1;
            else                        CPU_ACK <= 1'b1;
            MEM_EN <= 1'b0;
            state  <= ARB_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: two arbiters (latency 1 and 3) share stimulus and are checked against a transaction model.
`default_nettype none
module tb_data_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk, rst;
  logic cpu_req, cpu_rw, dbg_req, dbg_rw;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wd, dbg_wd;
  logic [DW-1:0] crd [2];
  logic [DW-1:0] drd [2];
  logic [DW-1:0] mwd [2];
  logic [DW-1:0] din [2];
  logic [AW-1:0] ma  [2];
  logic [7:0]    erun [2];
  logic [1:0] cack, dack, halt, en, mrw;
  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_l1 (
    .CK_REF(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_READ_WRN(cpu_rw), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wd),
    .CPU_RDATA(crd[0]), .CPU_ACK(cack[0]), .CPU_HALT(halt[0]),
    .DBG_REQ(dbg_req), .DBG_READ_WRN(dbg_rw), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wd),
    .DBG_RDATA(drd[0]), .DBG_ACK(dack[0]),
    .MEM_EN(en[0]), .MEM_ACCESS_READ_WRN(mrw[0]), .MEM_ACCESS_ADDRESS_BUS(ma[0]),
    .MEM_ACCESS_DATA_OUT_BUS(mwd[0]), .MEM_ACCESS_DATA_IN_BUS(din[0]));

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_l3 (
    .CK_REF(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_READ_WRN(cpu_rw), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wd),
    .CPU_RDATA(crd[1]), .CPU_ACK(cack[1]), .CPU_HALT(halt[1]),
    .DBG_REQ(dbg_req), .DBG_READ_WRN(dbg_rw), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wd),
    .DBG_RDATA(drd[1]), .DBG_ACK(dack[1]),
    .MEM_EN(en[1]), .MEM_ACCESS_READ_WRN(mrw[1]), .MEM_ACCESS_ADDRESS_BUS(ma[1]),
    .MEM_ACCESS_DATA_OUT_BUS(mwd[1]), .MEM_ACCESS_DATA_IN_BUS(din[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stand-in: the word depends on how long MEM_EN has been high, so an early capture reads a different value.
  function automatic logic [DW-1:0] ram_word(logic [AW-1:0] a);
    return {16'hCAFE, a ^ 16'h0011};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      erun[0] <= 8'd0;
      erun[1] <= 8'd0;
    end else begin
      erun[0] <= en[0] ? erun[0] + 8'd1 : 8'd0;
      erun[1] <= en[1] ? erun[1] + 8'd1 : 8'd0;
    end
  end
  assign din[0] = ram_word(ma[0]) ^ {erun[0], 24'h0};
  assign din[1] = ram_word(ma[1]) ^ {erun[1], 24'h0};

  // ---------------- transaction-level reference model ----------------
  bit            m_busy [2];
  int            m_cnt  [2];
  bit            m_win  [2];
  bit            m_last [2];
  bit            m_rw   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd   [2];
  logic [DW-1:0] m_crd  [2];
  logic [DW-1:0] m_drd  [2];

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_reset(int i);
    m_busy[i] = 0; m_cnt[i] = 0; m_win[i] = 0; m_last[i] = 1; m_rw[i] = 1;
    m_addr[i] = '0; m_wd[i] = '0; m_crd[i] = '0; m_drd[i] = '0;
  endtask

  task automatic model_update(int i);
    logic [DW-1:0] rv;
    if (rst) model_reset(i);
    else if (m_busy[i]) begin
      if (m_cnt[i] == lat(i) - 1 && m_rw[i]) begin
        rv = ram_word(m_addr[i]) ^ {8'(lat(i) - 1), 24'h0};
        if (m_win[i]) m_drd[i] = rv; else m_crd[i] = rv;
      end
      if (m_cnt[i] == lat(i)) m_busy[i] = 0;
      else m_cnt[i]++;
    end else if (cpu_req || dbg_req) begin
      m_win[i]  = (cpu_req && dbg_req) ? !m_last[i] : dbg_req;
      m_last[i] = m_win[i];
      m_rw[i]   = m_win[i] ? dbg_rw   : cpu_rw;
      m_addr[i] = m_win[i] ? dbg_addr : cpu_addr;
      m_wd[i]   = m_win[i] ? dbg_wd   : cpu_wd;
      m_busy[i] = 1;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (L=%0d) got %h expected %h at %0t", nm, lat(i), act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit e_en, e_ca, e_da;
    for (int i = 0; i < 2; i++) begin
      e_en = m_busy[i] && m_cnt[i] < lat(i);
      e_ca = m_busy[i] && m_cnt[i] == lat(i) && !m_win[i];
      e_da = m_busy[i] && m_cnt[i] == lat(i) &&  m_win[i];
      chk("mem_en",    i, 64'(en[i]),   64'(e_en));
      chk("read_wrn",  i, 64'(mrw[i]),  64'(m_rw[i]));
      chk("addr",      i, 64'(ma[i]),   64'(m_addr[i]));
      chk("wdata",     i, 64'(mwd[i]),  64'(m_wd[i]));
      chk("cpu_ack",   i, 64'(cack[i]), 64'(e_ca));
      chk("dbg_ack",   i, 64'(dack[i]), 64'(e_da));
      chk("cpu_rdata", i, 64'(crd[i]),  64'(m_crd[i]));
      chk("dbg_rdata", i, 64'(drd[i]),  64'(m_drd[i]));
      chk("cpu_halt",  i, 64'(halt[i]), 64'(cpu_req & ~e_ca));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    chk("en_async_rst", 0, 64'(en[0]), 64'd0);
    chk("en_async_rst", 1, 64'(en[1]), 64'd0);
    check_all();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (6) cyc();
  endtask

  // Cycles from request (at a falling edge) to the first ACK on the given port, per instance; -1 if none.
  task automatic wait_acks(input bit port, output int g1, output int g3,
                           output logic [DW-1:0] r1, output logic [DW-1:0] r3);
    g1 = -1; g3 = -1; r1 = '0; r3 = '0;
    for (int n = 1; n <= 24 && g3 < 0; n++) begin
      cyc();
      if (g1 < 0 && (port ? dack[0] : cack[0])) begin g1 = n; r1 = port ? drd[0] : crd[0]; end
      if (g3 < 0 && (port ? dack[1] : cack[1])) begin g3 = n; r3 = port ? drd[1] : crd[1]; end
    end
  endtask

  typedef struct {
    bit            port;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            lat1;
    int            lat3;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd3;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int g1, g3, cnt1, cnt3, encnt;
    logic [DW-1:0] r1, r3;
    int  na [2];
    int  acyc [2][4];
    bit  aport [2][4];
    int  exp_cyc [2][4];
    bit  exp_port [4];

    tbl[0] = '{0, 1, 16'h0010, 32'h0,         2, 4, 32'hCAFE_0001, 32'hC8FE_0001};
    tbl[1] = '{1, 1, 16'h1234, 32'h0,         2, 4, 32'hCAFE_1225, 32'hC8FE_1225};
    tbl[2] = '{0, 0, 16'h00FF, 32'h1234_5678, 2, 4, 32'h0,         32'h0};
    tbl[3] = '{1, 0, 16'h00FF, 32'h1234_5678, 2, 4, 32'h0,         32'h0};
    tbl[4] = '{0, 1, 16'hFFFF, 32'h0,         2, 4, 32'hCAFE_FFEE, 32'hC8FE_FFEE};
    exp_cyc[0] = '{2, 5, 8, 11};
    exp_cyc[1] = '{4, 9, 14, 19};
    exp_port   = '{0, 1, 0, 1};

    rst = 1'b1;
    cpu_req = 0; cpu_rw = 1; cpu_addr = '0; cpu_wd = '0;
    dbg_req = 0; dbg_rw = 1; dbg_addr = '0; dbg_wd = '0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    check_all();
    cyc();
    rst = 1'b0;
    cyc();

    // Single isolated transactions.
    for (int k = 0; k < 5; k++) begin
      if (tbl[k].port) begin dbg_req = 1; dbg_rw = tbl[k].rw; dbg_addr = tbl[k].addr; dbg_wd = tbl[k].wd; end
      else             begin cpu_req = 1; cpu_rw = tbl[k].rw; cpu_addr = tbl[k].addr; cpu_wd = tbl[k].wd; end
      wait_acks(tbl[k].port, g1, g3, r1, r3);
      cpu_req = 0;
      dbg_req = 0;
      chk("tbl_ack_cycle", 0, 64'(g1), 64'(tbl[k].lat1));
      chk("tbl_ack_cycle", 1, 64'(g3), 64'(tbl[k].lat3));
      if (tbl[k].rw) begin
        chk("tbl_rdata", 0, 64'(r1), 64'(tbl[k].rd1));
        chk("tbl_rdata", 1, 64'(r3), 64'(tbl[k].rd3));
      end
      drain();
    end

    // Both masters held high straight after reset: CPU first, then alternate.
    pulse_reset();
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0100;
    dbg_req = 1; dbg_rw = 1; dbg_addr = 16'h0200;
    na = '{0, 0};
    for (int n = 1; n <= 22; n++) begin
      cyc();
      for (int i = 0; i < 2; i++)
        if ((cack[i] || dack[i]) && na[i] < 4) begin
          acyc[i][na[i]]  = n;
          aport[i][na[i]] = dack[i];
          na[i]++;
        end
    end
    for (int i = 0; i < 2; i++) begin
      chk("rr_ack_count", i, 64'(na[i]), 64'd4);
      for (int k = 0; k < 4 && k < na[i]; k++) begin
        chk("rr_port", i, 64'(aport[i][k]), 64'(exp_port[k]));
        chk("rr_cycle", i, 64'(acyc[i][k]), 64'(exp_cyc[i][k]));
      end
    end
    drain();

    // Debug write at latency 3: bus held for exactly three MEM_EN cycles.
    dbg_req = 1; dbg_rw = 0; dbg_addr = 16'h00FF; dbg_wd = 32'h1234_5678;
    encnt = 0; g3 = -1;
    for (int n = 1; n <= 12 && g3 < 0; n++) begin
      cyc();
      if (en[1] && !mrw[1] && ma[1] == 16'h00FF && mwd[1] == 32'h1234_5678) encnt++;
      if (dack[1]) g3 = n;
    end
    chk("dbg_wr_en_cycles", 1, 64'(encnt), 64'd3);
    chk("dbg_wr_ack_cycle", 1, 64'(g3), 64'd4);
    drain();

    // Master changes its address after grant.
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0004;
    cyc();
    cpu_addr = 16'h0008;
    cyc();
    chk("addr_hold", 1, 64'(ma[1]), 64'h0004);
    cyc();
    chk("addr_hold", 1, 64'(ma[1]), 64'h0004);
    cyc();
    chk("addr_hold_ack", 1, 64'(cack[1]), 64'd1);
    drain();

    // Debug master drops REQ mid-access: still exactly one ACK.
    dbg_req = 1; dbg_rw = 1; dbg_addr = 16'h0042;
    cyc();
    dbg_req = 0;
    cnt1 = 0; cnt3 = 0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      cnt1 += int'(dack[0]);
      cnt3 += int'(dack[1]);
    end
    chk("drop_ack_count", 0, 64'(cnt1), 64'd1);
    chk("drop_ack_count", 1, 64'(cnt3), 64'd1);

    // Reset during ACCESS, then the held CPU request is served normally.
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0010;
    cyc();
    pulse_reset();
    wait_acks(0, g1, g3, r1, r3);
    chk("post_rst_ack_cycle", 0, 64'(g1), 64'd2);
    chk("post_rst_ack_cycle", 1, 64'(g3), 64'd4);
    chk("post_rst_rdata", 0, 64'(r1), 64'hCAFE_0001);
    drain();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      cyc();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
      end
      cpu_req  = ($urandom_range(0, 9) < 6);
      dbg_req  = ($urandom_range(0, 9) < 5);
      cpu_rw   = $urandom_range(0, 1) != 0;
      dbg_rw   = $urandom_range(0, 1) != 0;
      cpu_addr = AW'($urandom);
      dbg_addr = AW'($urandom);
      cpu_wd   = $urandom;
      dbg_wd   = $urandom;
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
